// File: rtl/grf_scoreboard.sv
// grf_scoreboard: per-register pending-write tracker for the MIPS pipeline.
// Sits beside the D stage and raises a decode stall for any operand whose producer
// has not yet reached the GRF write port. A same-cycle W-stage retire is visible to
// decode, which matches the GRF write-through behaviour.
// Optional build macro: SB_WAW_STALL_EN serialises writes to the same register.
// With it, each counter stays at 0 or 1.
module grf_scoreboard #(
    parameter int unsigned CNT_W = 2,
    parameter int unsigned TOT_W = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             d_valid,
    input  logic [4:0]       d_rs,
    input  logic             d_rs_use,
    input  logic [4:0]       d_rt,
    input  logic             d_rt_use,
    input  logic             d_wr_en,
    input  logic [4:0]       d_wr_reg,
    input  logic             w_en,
    input  logic [4:0]       w_reg,
    input  logic             flush,
    output logic             stall,
    output logic             issue,
    output logic [31:0]      busy_vec,
    output logic [TOT_W-1:0] pending_total,
    output logic             err_underflow
);

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    logic [31:0][CNT_W-1:0] cnt_q;
    logic [31:0][CNT_W-1:0] cnt_d;

    logic [31:0]      ret;     // retire this cycle, $0 excluded
    logic [31:0]      cnt_nz;  // current count non-zero
    logic [31:0]      eff_nz;  // count after the retire bypass is non-zero
    logic [31:0]      inc;
    logic [31:0]      dec;
    logic             rs_haz;
    logic             rt_haz;
    logic             sat;
    logic             waw;
    logic             err_d;
    logic [31:0]      busy_d;
    logic [TOT_W-1:0] total_d;

    // Retire bypass and effective (post-retire) occupancy for every register
    always_comb begin
        ret    = '0;
        cnt_nz = '0;
        eff_nz = '0;
        for (int r = 0; r < 32; r++) begin
            ret[r]    = w_en && (w_reg == 5'(r)) && (r != 0);
            cnt_nz[r] = (cnt_q[r] != '0);
            // eff = cnt - ret floored at 0; it is non-zero unless a lone entry retires now
            eff_nz[r] = cnt_nz[r] && !(ret[r] && (cnt_q[r] == CntOne));
        end
    end

    // Decode hazard detection and issue qualification
    always_comb begin
        rs_haz = d_rs_use && (d_rs != 5'd0) && eff_nz[d_rs];
        rt_haz = d_rt_use && (d_rt != 5'd0) && eff_nz[d_rt];
        // A full counter can still accept an issue if one of its entries retires now
        sat    = d_wr_en && (d_wr_reg != 5'd0) && (cnt_q[d_wr_reg] == CntMax)
                 && !ret[d_wr_reg];
`ifdef SB_WAW_STALL_EN
        waw    = d_wr_en && (d_wr_reg != 5'd0) && eff_nz[d_wr_reg];
`else
        waw    = 1'b0;
`endif
        stall  = d_valid && (rs_haz || rt_haz || sat || waw);
        issue  = d_valid && !stall;
    end

    // Next-state counters and sticky underflow flag
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_underflow;
        inc   = '0;
        dec   = '0;
        for (int r = 0; r < 32; r++) begin
            inc[r] = issue && d_wr_en && (d_wr_reg == 5'(r)) && (r != 0);
            dec[r] = ret[r] && cnt_nz[r];
        end
        if (flush) begin
            // Flush wins over same-cycle traffic and leaves the error flag alone
            cnt_d = '0;
        end else begin
            for (int r = 0; r < 32; r++) begin
                cnt_d[r] = cnt_q[r] + CNT_W'(inc[r]) - CNT_W'(dec[r]);
            end
            if ((ret & ~cnt_nz) != '0) begin
                err_d = 1'b1;
            end
        end
    end

    // Summary outputs derived from the next-state counters
    always_comb begin
        busy_d  = '0;
        total_d = '0;
        for (int r = 0; r < 32; r++) begin
            busy_d[r] = (cnt_d[r] != '0);
            total_d   = total_d + TOT_W'(cnt_d[r]);
        end
    end

    // State register; reset beats flush, issue and retire
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q         <= '0;
            busy_vec      <= '0;
            pending_total <= '0;
            err_underflow <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            busy_vec      <= busy_d;
            pending_total <= total_d;
            err_underflow <= err_d;
        end
    end

endmodule

// File: tb/tb_grf_scoreboard.sv
// Bench for grf_scoreboard: directed scenarios followed by random traffic, all
// checked against an integer-array model of the pending-write counts.
module tb_grf_scoreboard;

    localparam int CNT_W = 2;
    localparam int TOT_W = 7;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             d_valid;
    logic [4:0]       d_rs;
    logic             d_rs_use;
    logic [4:0]       d_rt;
    logic             d_rt_use;
    logic             d_wr_en;
    logic [4:0]       d_wr_reg;
    logic             w_en;
    logic [4:0]       w_reg;
    logic             flush;
    logic             stall;
    logic             issue;
    logic [31:0]      busy_vec;
    logic [TOT_W-1:0] pending_total;
    logic             err_underflow;

    grf_scoreboard #(.CNT_W(CNT_W), .TOT_W(TOT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .d_valid      (d_valid),
        .d_rs         (d_rs),
        .d_rs_use     (d_rs_use),
        .d_rt         (d_rt),
        .d_rt_use     (d_rt_use),
        .d_wr_en      (d_wr_en),
        .d_wr_reg     (d_wr_reg),
        .w_en         (w_en),
        .w_reg        (w_reg),
        .flush        (flush),
        .stall        (stall),
        .issue        (issue),
        .busy_vec     (busy_vec),
        .pending_total(pending_total),
        .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int mcnt[32];
    bit merr;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_ret(input int r);
        return w_en && (int'(w_reg) == r) && (r != 0);
    endfunction

    function automatic int m_eff(input int r);
        int e;
        e = mcnt[r] - (m_ret(r) ? 1 : 0);
        return (e < 0) ? 0 : e;
    endfunction

    function automatic bit m_stall();
        bit s;
        s = 0;
        if (d_rs_use && d_rs != 0 && m_eff(int'(d_rs)) > 0) s = 1;
        if (d_rt_use && d_rt != 0 && m_eff(int'(d_rt)) > 0) s = 1;
        if (d_wr_en && d_wr_reg != 0 && mcnt[int'(d_wr_reg)] == MAXC && !m_ret(int'(d_wr_reg)))
            s = 1;
`ifdef SB_WAW_STALL_EN
        if (d_wr_en && d_wr_reg != 0 && m_eff(int'(d_wr_reg)) > 0) s = 1;
`endif
        return d_valid && s;
    endfunction

    // Apply one cycle of inputs just after the falling edge
    task automatic drive(input bit rst, input bit v, input logic [4:0] rs, input bit rsu,
                         input logic [4:0] rt, input bit rtu, input bit we,
                         input logic [4:0] wr, input bit wen, input logic [4:0] wreg,
                         input bit fl);
        @(negedge clk);
        reset    = rst;
        d_valid  = v;
        d_rs     = rs;
        d_rs_use = rsu;
        d_rt     = rt;
        d_rt_use = rtu;
        d_wr_en  = we;
        d_wr_reg = wr;
        w_en     = wen;
        w_reg    = wreg;
        flush    = fl;
        #1;
    endtask

    // Check combinational outputs, advance the model and the clock, check registered outputs
    task automatic tick();
        bit          exp_stall;
        bit          exp_issue;
        logic [31:0] b;
        int          tot;
        exp_stall = m_stall();
        exp_issue = d_valid && !exp_stall;
        check_eq("stall", {63'd0, stall}, {63'd0, exp_stall});
        check_eq("issue", {63'd0, issue}, {63'd0, exp_issue});
        if (reset) begin
            foreach (mcnt[r]) mcnt[r] = 0;
            merr = 0;
        end else if (flush) begin
            foreach (mcnt[r]) mcnt[r] = 0;
        end else begin
            for (int r = 1; r < 32; r++) begin
                if (m_ret(r) && mcnt[r] == 0) merr = 1;
                if (m_ret(r) && mcnt[r] > 0) mcnt[r]--;
                if (exp_issue && d_wr_en && int'(d_wr_reg) == r) mcnt[r]++;
            end
        end
        @(posedge clk);
        #1;
        b   = '0;
        tot = 0;
        for (int r = 0; r < 32; r++) begin
            b[r] = (mcnt[r] != 0);
            tot += mcnt[r];
        end
        check_eq("busy_vec", {32'd0, busy_vec}, {32'd0, b});
        check_eq("pending_total", {57'd0, pending_total}, 64'(tot));
        check_eq("err_underflow", {63'd0, err_underflow}, {63'd0, merr});
    endtask

    task automatic do_reset();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic issue_wr(input logic [4:0] r);
        drive(0, 1, 0, 0, 0, 0, 1, r, 0, 0, 0);
        tick();
    endtask

    initial begin
        foreach (mcnt[r]) mcnt[r] = 0;
        merr = 0;
        do_reset();

        // Idle after reset
        drive(0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
        check_eq("idle_stall", {63'd0, stall}, 64'd0);
        check_eq("idle_busy", {32'd0, busy_vec}, 64'd0);
        check_eq("idle_total", {57'd0, pending_total}, 64'd0);
        tick();

        // RAW on $8 with retire bypass in cycle 3
        issue_wr(8);
        drive(0, 1, 8, 1, 0, 0, 0, 0, 0, 0, 0);
        check_eq("raw_stall", {63'd0, stall}, 64'd1);
        check_eq("raw_busy8", {63'd0, busy_vec[8]}, 64'd1);
        tick();
        drive(0, 1, 8, 1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 1, 8, 1, 0, 0, 0, 0, 1, 8, 0);
        check_eq("bypass_stall", {63'd0, stall}, 64'd0);
        tick();
        check_eq("busy8_clear", {63'd0, busy_vec[8]}, 64'd0);

`ifndef SB_WAW_STALL_EN
        // Saturation on $3
        do_reset();
        issue_wr(3);
        issue_wr(3);
        issue_wr(3);
        check_eq("sat_total", {57'd0, pending_total}, 64'd3);
        drive(0, 1, 0, 0, 0, 0, 1, 3, 0, 0, 0);
        check_eq("sat_stall", {63'd0, stall}, 64'd1);
        tick();
        drive(0, 1, 0, 0, 0, 0, 1, 3, 1, 3, 0);
        check_eq("sat_ret_issue", {63'd0, issue}, 64'd1);
        tick();
        check_eq("sat_ret_total", {57'd0, pending_total}, 64'd3);
`else
        // WAW serialisation on $6
        do_reset();
        issue_wr(6);
        drive(0, 1, 0, 0, 0, 0, 1, 6, 0, 0, 0);
        check_eq("waw_stall", {63'd0, stall}, 64'd1);
        tick();
        drive(0, 1, 0, 0, 0, 0, 1, 6, 0, 0, 0);
        check_eq("waw_stall_hold", {63'd0, stall}, 64'd1);
        tick();
        drive(0, 1, 0, 0, 0, 0, 1, 6, 1, 6, 0);
        check_eq("waw_release", {63'd0, stall}, 64'd0);
        tick();
        check_eq("waw_total", {57'd0, pending_total}, 64'd1);
`endif

        // Same-cycle issue and retire on $10
        do_reset();
        issue_wr(10);
        drive(0, 1, 0, 0, 0, 0, 1, 10, 1, 10, 0);
        check_eq("swap10_issue", {63'd0, issue}, 64'd1);
        tick();
        check_eq("swap10_total", {57'd0, pending_total}, 64'd1);
        check_eq("swap10_busy", {63'd0, busy_vec[10]}, 64'd1);

        // Underflow on $7 is sticky until reset
        do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0);
        tick();
        check_eq("uflow_set", {63'd0, err_underflow}, 64'd1);
        issue_wr(2);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0);
        tick();
        check_eq("uflow_sticky", {63'd0, err_underflow}, 64'd1);
        do_reset();
        check_eq("uflow_reset", {63'd0, err_underflow}, 64'd0);

        // Flush discards pending entries and a same-cycle issue
        issue_wr(4);
        issue_wr(9);
        check_eq("pre_flush_total", {57'd0, pending_total}, 64'd2);
        drive(0, 1, 0, 0, 0, 0, 1, 12, 0, 0, 1);
        tick();
        check_eq("flush_busy", {32'd0, busy_vec}, 64'd0);
        check_eq("flush_total", {57'd0, pending_total}, 64'd0);

        // $0 is never tracked
        do_reset();
        issue_wr(5);
        drive(0, 1, 0, 1, 0, 1, 1, 0, 1, 0, 0);
        check_eq("zero_stall", {63'd0, stall}, 64'd0);
        tick();
        check_eq("zero_total", {57'd0, pending_total}, 64'd1);
        check_eq("zero_err", {63'd0, err_underflow}, 64'd0);

        // Random traffic concentrated on a few registers to provoke hazards
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(0, 149) == 0), 1'($urandom_range(0, 3) != 0),
                  5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)),
                  1'($urandom_range(0, 9) < 4), 5'($urandom_range(0, 7)),
                  1'($urandom_range(0, 49) == 0));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/grf_scoreboard.md
Name: grf_scoreboard

Overview:
- Tracks outstanding register writes for the pipelined MIPS core, with a pending counter for each of the 32 GRF registers.
- Sits beside the D stage. Generates the decode stall for operands whose producer has not yet reached the GRF write port.
- Instructions increment a counter on issue; retirement at the W-stage write port decrements it.
- Mirrors the GRF write-through rule: a same-cycle retire is visible to decode.

Parameters:
CNT_W, 2, width of each per-register pending counter; maximum outstanding writes per register = 2^CNT_W - 1
TOT_W, 7, width of pending_total (must hold 32*(2^CNT_W-1))

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
d_valid  input  1  D-stage instruction present
d_rs  input  5  source register rs
d_rs_use  input  1  instruction reads rs
d_rt  input  5  source register rt
d_rt_use  input  1  instruction reads rt
d_wr_en  input  1  instruction will write a register
d_wr_reg  input  5  destination register
w_en  input  1  W stage writes GRF this cycle
w_reg  input  5  W-stage destination register
flush  input  1  discard all pending entries
stall  output  1  combinational decode stall
issue  output  1  combinational, d_valid & ~stall
busy_vec  output  32  registered, bit r = (cnt[r] != 0)
pending_total  output  TOT_W  registered sum of all counters
err_underflow  output  1  sticky, registered: retire seen with cnt == 0

Behaviour:
- Reset: clk and reset are decided as above, synchronous, active-high. On reset, all cnt = 0, busy_vec = 0, pending_total = 0, err_underflow = 0. Reset beats flush, issue and retire in the same cycle.
- Register 0 is never tracked. cnt[0] stays 0. Issue with d_wr_reg = 0 and retire with w_reg = 0 are no-ops. Reads of $0 never stall.
- Retire bypass: ret_r = w_en & (w_reg == r) & (r != 0).
- Effective count: eff[r] = cnt[r] - ret_r, floored at 0.
- Stall equation:
  - stall = d_valid & (rs_haz | rt_haz | sat)
  - rs_haz = d_rs_use & d_rs != 0 & eff[d_rs] != 0 (rt_haz likewise)
  - sat = d_wr_en & d_wr_reg != 0 & cnt[d_wr_reg] == 2^CNT_W-1 & ~ret_{d_wr_reg}
- Counter update at posedge, when not reset:
  - If flush: all cnt = 0, pending_total = 0. A same-cycle issue/retire is discarded. err_underflow is unchanged.
  - Otherwise, for each r: cnt[r] <= cnt[r] + inc_r - dec_r.
    - inc_r = issue & d_wr_en & d_wr_reg == r
    - dec_r = ret_r & cnt[r] != 0
  - Issue and retire on the same register in the same cycle leave cnt unchanged.
- Underflow: ret_r with cnt[r] == 0 sets err_underflow (sticky until reset). The counter stays 0.
- pending_total and busy_vec are recomputed from the next-state counters, so they are valid the cycle after the update. Latency is 1 cycle.
- stall has zero latency: it is purely combinational from the inputs and current state. The block does not generate stall from flush.
- d_valid = 0: stall = 0, issue = 0, no increment.

Optional Feature:
SB_WAW_STALL_EN
- Defined: an extra stall term applies: d_valid & d_wr_en & d_wr_reg != 0 & eff[d_wr_reg] != 0 (WAW serialization). Counters never exceed 1, and the sat term becomes unreachable.
- Undefined: multiple in-flight writes to the same register are allowed, up to the saturation limit.

Test Plan:
- Reset then idle: busy_vec = 0, pending_total = 0, stall = 0 for d_valid=1, d_rs_use=1, d_rs=5.
- Issue write $8 (cycle 0), then read $8 in cycle 1 -> stall=1, busy_vec[8]=1. Retire $8 in cycle 3 with the read still held -> stall=0 in that same cycle (bypass). busy_vec[8]=0 from cycle 4.
- Default build (SB_WAW_STALL_EN undefined): issue writes to $3 three times with no retire -> cnt=3, pending_total=3. A fourth issue to $3 -> stall=1 (sat). A fourth issue in the same cycle as a $3 retire -> issue=1, cnt stays 3.
- Same-cycle issue and retire on $10 with cnt[10]=1 -> cnt[10] stays 1, pending_total unchanged.
- Retire $7 with cnt[7]=0 -> err_underflow=1 next cycle and remains 1 after later traffic. Reset clears it.
- Pending $4 and $9, then flush together with an issue to $12 -> next cycle busy_vec=0, pending_total=0.
- SB_WAW_STALL_EN defined: issue $6, then write $6 again -> stall=1 until the $6 retire cycle.
- Reads of $0 and writes to $0 -> never stall, never counted.
